// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch-side, data-side and memory-side signals of mem_port_arbiter.
// slave is the arbiter's view; master is the view of the requesters plus memory.
interface mem_port_arbiter_if;
    logic        i_req;
    logic [31:0] i_address;
    logic [1:0]  i_access_size;
    logic        i_done;
    logic [31:0] i_rdata;
    logic        i_stall;

    logic        d_req;
    logic        d_rw;
    logic [31:0] d_address;
    logic [1:0]  d_access_size;
    logic [31:0] d_wdata;
    logic        d_done;
    logic [31:0] d_rdata;
    logic        d_stall;

    logic        mem_enable;
    logic        mem_rw;
    logic [31:0] mem_address;
    logic [1:0]  mem_access_size;
    logic [31:0] mem_data_in;
    logic [31:0] mem_data_out;

    modport slave (
        input  i_req, i_address, i_access_size,
        output i_done, i_rdata, i_stall,
        input  d_req, d_rw, d_address, d_access_size, d_wdata,
        output d_done, d_rdata, d_stall,
        output mem_enable, mem_rw, mem_address, mem_access_size, mem_data_in,
        input  mem_data_out
    );

    modport master (
        output i_req, i_address, i_access_size,
        input  i_done, i_rdata, i_stall,
        output d_req, d_rw, d_address, d_access_size, d_wdata,
        input  d_done, d_rdata, d_stall,
        input  mem_enable, mem_rw, mem_address, mem_access_size, mem_data_in,
        output mem_data_out
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between fetch (read-only) and memory stage (read/write).
// One grant at a time, MEM_LATENCY enable cycles per access, bounded D priority.
module mem_port_arbiter #(
    parameter int MEM_LATENCY = 2,
    parameter int D_MAX       = 4
) (
    input  logic               clock,
    input  logic               reset,
    mem_port_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

    localparam int             SW         = $clog2(D_MAX + 1);
    localparam logic [1:0]     LAT_INIT   = 2'(MEM_LATENCY - 1);
    localparam logic [SW-1:0]  STREAK_MAX = SW'(D_MAX);

    state_t        state_q, state_d;
    logic [1:0]    lat_cnt_q, lat_cnt_d;
    logic [SW-1:0] d_streak_q, d_streak_d;
    logic          en_q, en_d;
    logic          rw_q, rw_d;
    logic [31:0]   addr_q, addr_d;
    logic [1:0]    size_q, size_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          i_done_q, i_done_d;
    logic          d_done_q, d_done_d;
    logic [31:0]   i_rdata_q, i_rdata_d;
    logic [31:0]   d_rdata_q, d_rdata_d;

    logic idle_ok, grant_i, grant_d;

    // The IDLE cycle carrying a done pulse is a dead turnaround cycle: the completing
    // stage needs it to advance, so neither side may be granted until the next cycle.
    assign idle_ok = (state_q == IDLE) && !i_done_q && !d_done_q;
    assign grant_i = idle_ok && bus.i_req && (!bus.d_req || d_streak_q == STREAK_MAX);
    assign grant_d = idle_ok && bus.d_req && !grant_i;

    always_comb begin
        state_d    = state_q;
        lat_cnt_d  = lat_cnt_q;
        d_streak_d = d_streak_q;
        en_d       = en_q;
        rw_d       = rw_q;
        addr_d     = addr_q;
        size_d     = size_q;
        wdata_d    = wdata_q;
        i_done_d   = 1'b0;
        d_done_d   = 1'b0;
        i_rdata_d  = i_rdata_q;
        d_rdata_d  = d_rdata_q;

        case (state_q)
            IDLE: begin
                if (grant_i) begin
                    state_d    = BUSY_I;
                    lat_cnt_d  = LAT_INIT;
                    en_d       = 1'b1;
                    rw_d       = 1'b1;
                    addr_d     = bus.i_address;
                    size_d     = bus.i_access_size;
                    wdata_d    = 32'h0;
                    d_streak_d = '0;
                end else if (grant_d) begin
                    state_d    = BUSY_D;
                    lat_cnt_d  = LAT_INIT;
                    en_d       = 1'b1;
                    rw_d       = bus.d_rw;
                    addr_d     = bus.d_address;
                    size_d     = bus.d_access_size;
                    wdata_d    = bus.d_wdata;
                    if (!bus.i_req)
                        d_streak_d = '0;
                    else if (d_streak_q != STREAK_MAX)
                        d_streak_d = d_streak_q + 1'b1;
                end
            end
            BUSY_I, BUSY_D: begin
                if (lat_cnt_q != 2'd0) begin
                    lat_cnt_d = lat_cnt_q - 2'd1;
                end else begin
                    state_d = IDLE;
                    en_d    = 1'b0;
                    if (state_q == BUSY_I) begin
                        i_done_d  = 1'b1;
                        i_rdata_d = bus.mem_data_out;
                    end else begin
                        d_done_d = 1'b1;
                        if (rw_q)
                            d_rdata_d = bus.mem_data_out;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            lat_cnt_q  <= 2'd0;
            d_streak_q <= '0;
            en_q       <= 1'b0;
            rw_q       <= 1'b0;
            addr_q     <= 32'h0;
            size_q     <= 2'd0;
            wdata_q    <= 32'h0;
            i_done_q   <= 1'b0;
            d_done_q   <= 1'b0;
            i_rdata_q  <= 32'h0;
            d_rdata_q  <= 32'h0;
        end else begin
            state_q    <= state_d;
            lat_cnt_q  <= lat_cnt_d;
            d_streak_q <= d_streak_d;
            en_q       <= en_d;
            rw_q       <= rw_d;
            addr_q     <= addr_d;
            size_q     <= size_d;
            wdata_q    <= wdata_d;
            i_done_q   <= i_done_d;
            d_done_q   <= d_done_d;
            i_rdata_q  <= i_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    assign bus.i_done          = i_done_q;
    assign bus.i_rdata         = i_rdata_q;
    assign bus.i_stall         = bus.i_req & ~i_done_q;
    assign bus.d_done          = d_done_q;
    assign bus.d_rdata         = d_rdata_q;
    assign bus.d_stall         = bus.d_req & ~d_done_q;
    assign bus.mem_enable      = en_q;
    assign bus.mem_rw          = rw_q;
    assign bus.mem_address     = addr_q;
    assign bus.mem_access_size = size_q;
    assign bus.mem_data_in     = wdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios then random traffic, every cycle
// compared against a transaction-level reference model.
module tb_mem_port_arbiter;
    localparam int MEM_LATENCY = 2;
    localparam int D_MAX       = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    mem_port_arbiter_if bus();

    mem_port_arbiter #(.MEM_LATENCY(MEM_LATENCY), .D_MAX(D_MAX)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic [31:0] memf(input logic [31:0] a);
        if (a == 32'h8002_0000) return 32'h3c1d_8002;
        return {a[15:0], a[31:16]} ^ 32'ha5a5_0f0f;
    endfunction

    // memory model: valid data only while enabled, inverted garbage otherwise
    assign bus.mem_data_out = memf(bus.mem_address) ^ (bus.mem_enable ? 32'h0 : 32'hffff_ffff);

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // reference model: owner 0=none 1=I 2=D, left = enable cycles still to run
    int          m_owner, m_left, m_streak;
    logic        m_idone, m_ddone, m_rw;
    logic [31:0] m_irdata, m_drdata, m_addr, m_wdata;
    logic [1:0]  m_size;

    task automatic model_edge();
        logic ndi, ndd, pick_i;
        ndi = 1'b0;
        ndd = 1'b0;
        if (reset) begin
            m_owner = 0; m_left = 0; m_streak = 0;
            m_idone = 0; m_ddone = 0; m_rw = 0;
            m_irdata = 0; m_drdata = 0; m_addr = 0; m_wdata = 0; m_size = 0;
            return;
        end
        if (m_owner != 0) begin
            if (m_left == 1) begin
                if (m_owner == 1) begin
                    ndi = 1'b1;
                    m_irdata = memf(m_addr);
                end else begin
                    ndd = 1'b1;
                    if (m_rw) m_drdata = memf(m_addr);
                end
                m_owner = 0;
                m_left  = 0;
            end else begin
                m_left--;
            end
        end else if (!m_idone && !m_ddone && (bus.i_req || bus.d_req)) begin
            pick_i = bus.i_req && (!bus.d_req || m_streak == D_MAX);
            m_left = MEM_LATENCY;
            if (pick_i) begin
                m_owner = 1; m_addr = bus.i_address; m_size = bus.i_access_size;
                m_rw = 1'b1; m_wdata = 32'h0; m_streak = 0;
            end else begin
                m_owner = 2; m_addr = bus.d_address; m_size = bus.d_access_size;
                m_rw = bus.d_rw; m_wdata = bus.d_wdata;
                m_streak = bus.i_req ? ((m_streak < D_MAX) ? m_streak + 1 : D_MAX) : 0;
            end
        end
        m_idone = ndi;
        m_ddone = ndd;
    endtask

    logic       prev_en = 1'b0;
    logic [9:0] grant_log = '0;
    int         grant_cnt = 0;
    int         wr_cycles = 0;

    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
        chk("i_done",   32'(bus.i_done),     32'(m_idone));
        chk("i_rdata",  bus.i_rdata,         m_irdata);
        chk("i_stall",  32'(bus.i_stall),    32'(bus.i_req & ~m_idone));
        chk("d_done",   32'(bus.d_done),     32'(m_ddone));
        chk("d_rdata",  bus.d_rdata,         m_drdata);
        chk("d_stall",  32'(bus.d_stall),    32'(bus.d_req & ~m_ddone));
        chk("mem_en",   32'(bus.mem_enable), 32'(m_owner != 0));
        chk("mem_rw",   32'(bus.mem_rw),     32'(m_rw));
        chk("mem_addr", bus.mem_address,     m_addr);
        chk("mem_size", 32'(bus.mem_access_size), 32'(m_size));
        chk("mem_din",  bus.mem_data_in,     m_wdata);
        if (bus.mem_enable && !prev_en) begin
            grant_log = {grant_log[8:0], bus.mem_address == 32'h0000_1000};
            grant_cnt++;
        end
        if (bus.mem_enable && !bus.mem_rw && bus.mem_data_in == 32'hdead_beef) wr_cycles++;
        prev_en = bus.mem_enable;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        bus.i_req = 0; bus.i_address = 0; bus.i_access_size = 0;
        bus.d_req = 0; bus.d_rw = 0; bus.d_address = 0; bus.d_access_size = 0; bus.d_wdata = 0;

        // reset
        step(); step();
        chk("rst_en", 32'(bus.mem_enable), 32'h0);

        // lone fetch
        reset = 0;
        bus.i_req = 1; bus.i_address = 32'h8002_0000; bus.i_access_size = 2'd2;
        seen = 0;
        for (int c = 1; c <= 8 && !seen; c++) begin
            step();
            if (bus.i_done) begin
                seen = 1;
                chk("fetch_lat", c, 3);
                chk("fetch_data", bus.i_rdata, 32'h3c1d_8002);
            end
        end
        chk("fetch_seen", 32'(seen), 32'h1);
        bus.i_req = 0;
        step(); step();

        // data write
        bus.d_req = 1; bus.d_rw = 0; bus.d_address = 32'h8002_0010;
        bus.d_access_size = 2'd2; bus.d_wdata = 32'hdead_beef;
        wr_cycles = 0; seen = 0;
        for (int c = 1; c <= 8 && !seen; c++) begin
            step();
            if (bus.d_done) begin
                seen = 1;
                chk("wr_lat", c, 3);
                chk("wr_rdata_kept", bus.d_rdata, 32'h0);
            end
        end
        chk("wr_seen", 32'(seen), 32'h1);
        chk("wr_cycles", wr_cycles, MEM_LATENCY);
        bus.d_req = 0;
        step(); step();

        // contention, both held continuously
        bus.i_req = 1; bus.i_address = 32'h0000_1000; bus.i_access_size = 2'd2;
        bus.d_req = 1; bus.d_rw = 1; bus.d_address = 32'h0000_2000; bus.d_wdata = 0;
        grant_cnt = 0;
        for (int c = 0; c < 100 && grant_cnt < 10; c++) step();
        chk("grant_cnt", grant_cnt, 10);
        chk("grant_order", 32'(grant_log), 32'b00_0010_0001);
        bus.i_req = 0; bus.d_req = 0;
        for (int c = 0; c < 6; c++) step();

        // reset in the middle of a data access
        bus.d_req = 1; bus.d_rw = 1; bus.d_address = 32'h0000_3000;
        step();
        chk("midrst_en", 32'(bus.mem_enable), 32'h1);
        reset = 1; bus.d_req = 0; bus.i_req = 1; bus.i_address = 32'h0000_1000;
        step();
        chk("midrst_off", 32'(bus.mem_enable), 32'h0);
        chk("midrst_nodone", 32'(bus.d_done), 32'h0);
        step();
        reset = 0;
        step();
        chk("postrst_en", 32'(bus.mem_enable), 32'h1);
        chk("postrst_i", 32'(bus.mem_rw), 32'h1);

        // done-cycle ignore: i_req held through i_done
        seen = 0;
        for (int c = 0; c < 8 && !seen; c++) begin
            step();
            if (bus.i_done) seen = 1;
        end
        chk("ign_seen", 32'(seen), 32'h1);
        step();
        chk("ign_no_regrant", 32'(bus.mem_enable), 32'h0);
        step();
        chk("ign_regrant", 32'(bus.mem_enable), 32'h1);
        bus.i_req = 0;
        for (int c = 0; c < 6; c++) step();

        // random traffic
        for (int c = 0; c < 2000; c++) begin
            reset = ($urandom_range(0, 149) == 0);
            bus.i_req = ($urandom_range(0, 2) != 0);
            bus.d_req = ($urandom_range(0, 2) != 0);
            bus.i_address = $urandom; bus.i_access_size = 2'($urandom);
            bus.d_address = $urandom; bus.d_access_size = 2'($urandom);
            bus.d_rw = 1'($urandom); bus.d_wdata = $urandom;
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
